regfile_scrub: RTL
==================

# regfile_scrub

Parametrised successor to the CPU register file: two combinational read ports, a 16-bit register-pair read view, a single-byte or register-pair write port, and an optional hardwired-zero register. Reset is synchronous, so storage is not reset directly. Instead, a scrub state machine zeroes every register, one per cycle, after reset, and raises `ready` when done. The block sits between decode (read addresses) and writeback (write port) in the datapath; the core stalls while `ready` is low.

## Interface
- `REG_COUNT`, default 16: number of registers. Must be a power of two and at least 2.
- `DATA_WIDTH`, default 8: register width in bits.
- `ADDR_WIDTH`, default `$clog2(REG_COUNT)`: address width.
- `ZERO_REG`, default 0: when 1, register 0 always reads 0 and writes to it are discarded.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `readAddr1`  in  ADDR_WIDTH  read port 1 address.
- `readAddr2`  in  ADDR_WIDTH  read port 2 address.
- `reg1`  out  DATA_WIDTH  contents of `regs[readAddr1]`.
- `reg2`  out  DATA_WIDTH  contents of `regs[readAddr2]`.
- `pair1`  out  2*DATA_WIDTH  `{regs[readAddr1|1], regs[readAddr1&~1]}`.
- `writeAddr`  in  ADDR_WIDTH  write address.
- `writeData`  in  DATA_WIDTH  write data; the low byte in pair mode.
- `writeDataHi`  in  DATA_WIDTH  high byte in pair mode; ignored otherwise.
- `writeEn`  in  1  write strobe.
- `writePair`  in  1  qualifies `writeEn` as a pair write.
- `ready`  out  1  scrub complete; writes are accepted and reads are valid.

## Operation
- States:
  - SCRUB, counter `cnt` of ADDR_WIDTH bits.
  - READY.
- Any edge with `rst_n`=0 → SCRUB, `cnt`=0, `ready`=0. This applies from any state, including mid-scrub, which restarts the scrub.
- SCRUB with `rst_n`=1:
  - Each edge writes `regs[cnt]` ← 0.
  - `cnt` increments.
  - On the edge where `cnt`==REG_COUNT-1 the state goes to READY.
- SCRUB ignores `writeEn`/`writePair` entirely; no queuing.
- READY, `writeEn`=1, `writePair`=0: `regs[writeAddr]` ← `writeData`.
- READY, `writeEn`=1, `writePair`=1:
  - `regs[writeAddr&~1]` ← `writeData`.
  - `regs[writeAddr|1]` ← `writeDataHi`.
  - The LSB of `writeAddr` is ignored.
- `writePair` without `writeEn`: no effect.
- ZERO_REG=1:
  - Any write targeting index 0 drops that byte only; the pair's odd half is still written.
  - Reads of index 0 return 0, including the low half of `pair1`.
- Reads are combinational from storage.
- While `ready`=0, `reg1`, `reg2` and `pair1` are forced to 0.
- Read addresses are always in range (power-of-two depth); no wrap handling is needed.

## Timing
- Reset values:
  - `ready`=0.
  - `reg1`=`reg2`=0 and `pair1`=0 for as long as `ready`=0.
- Scrub latency: `ready` rises exactly REG_COUNT rising edges after the first edge sampled with `rst_n`=1.
- Write-to-read latency:
  - A write is visible on the read ports in the cycle after its edge.
  - With bypass compiled in (see Configuration), the write is also visible combinationally in the same cycle.
- Simultaneous read and write of the same address in the same cycle:
  - Without bypass, the read returns the old value.
  - With bypass, the read returns the new value.
- Two read ports addressing the same register return identical data.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - Applies when `ready`=1 and `writeEn`=1.
  - Each read byte (`reg1`, `reg2`, both halves of `pair1`) whose index matches a byte being written this cycle returns the incoming byte: `writeData`, or `writeDataHi` for the odd half of a pair write.
  - ZERO_REG masking takes priority over bypass.
- `REGFILE_BYPASS_EN` undefined: reads always return stored values; there is no combinational path from the write port to the read ports.

## Test plan
- Scrub timing:
  - Stimulus: hold `rst_n`=0 for 3 cycles, release, with REG_COUNT=16.
  - Response: `ready` is 0 for 16 edges and 1 after the 16th edge; every register then reads 0x00.
- Byte write and pair read:
  - Stimulus: write 0x5A to r3, then 0xC3 to r2, then set `readAddr1`=3.
  - Response: `reg1`=0x5A and `pair1`=0x5AC3.
- Pair write on an odd address:
  - Stimulus: `writePair`=1, `writeAddr`=5, `writeData`=0x34, `writeDataHi`=0x12.
  - Response: r4=0x34, r5=0x12.
- ZERO_REG=1:
  - Stimulus: pair write to address 0 with 0xAA/0xBB.
  - Response: r0 reads 0x00, r1 reads 0xBB, `pair1`@0 = 0xBB00.
- Reset mid-scrub and during writes:
  - Stimulus: assert `rst_n`=0 at scrub cycle 7; during scrub, drive `writeEn`=1 to r9 with 0xFF.
  - Response: `ready` rises exactly 16 edges after the second release; r9 reads 0x00.
- Bypass, same-cycle read/write of r6 with data 0x77 in READY:
  - `REGFILE_BYPASS_EN` defined: `reg2`=0x77 in the same cycle.
  - `REGFILE_BYPASS_EN` undefined: `reg2` shows the old value, then 0x77 on the next cycle.

Source files
------------

// File: rtl/regfile_scrub.sv
// Register file with post-reset scrub, two read ports, a pair view and byte/pair writes.
// Define REGFILE_BYPASS_EN to forward same-cycle writes onto the read ports.
module regfile_scrub #(
    parameter int REG_COUNT  = 16,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = $clog2(REG_COUNT),
    parameter int ZERO_REG   = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   readAddr1,
    input  logic [ADDR_WIDTH-1:0]   readAddr2,
    output logic [DATA_WIDTH-1:0]   reg1,
    output logic [DATA_WIDTH-1:0]   reg2,
    output logic [2*DATA_WIDTH-1:0] pair1,
    input  logic [ADDR_WIDTH-1:0]   writeAddr,
    input  logic [DATA_WIDTH-1:0]   writeData,
    input  logic [DATA_WIDTH-1:0]   writeDataHi,
    input  logic                    writeEn,
    input  logic                    writePair,
    output logic                    ready
);

    localparam logic [0:0] SCRUB = 1'b0;
    localparam logic [0:0] READY = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(REG_COUNT - 1);

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0] regs [REG_COUNT];

    logic [ADDR_WIDTH-1:0] wr_lo;
    logic [ADDR_WIDTH-1:0] wr_hi;
    logic [ADDR_WIDTH-1:0] rd_lo;
    logic [ADDR_WIDTH-1:0] rd_hi;

    assign ready = (state == READY);
    assign wr_lo = {writeAddr[ADDR_WIDTH-1:1], 1'b0};
    assign wr_hi = {writeAddr[ADDR_WIDTH-1:1], 1'b1};
    assign rd_lo = {readAddr1[ADDR_WIDTH-1:1], 1'b0};
    assign rd_hi = {readAddr1[ADDR_WIDTH-1:1], 1'b1};

    // Storage is never reset directly; the scrub walk clears it instead.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SCRUB;
            cnt   <= '0;
        end else if (state == SCRUB) begin
            regs[cnt] <= '0;
            cnt       <= cnt + ADDR_WIDTH'(1);
            if (cnt == LAST)
                state <= READY;
        end else if (writeEn) begin
            if (writePair) begin
                if (!(ZERO_REG != 0 && wr_lo == '0))
                    regs[wr_lo] <= writeData;
                regs[wr_hi] <= writeDataHi;
            end else if (!(ZERO_REG != 0 && writeAddr == '0)) begin
                regs[writeAddr] <= writeData;
            end
        end
    end

    function automatic logic [DATA_WIDTH-1:0] rd(input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] v;
        v = regs[a];
`ifdef REGFILE_BYPASS_EN
        if (ready && writeEn) begin
            if (writePair) begin
                if (a == wr_hi)
                    v = writeDataHi;
                else if (a == wr_lo)
                    v = writeData;
            end else if (a == writeAddr) begin
                v = writeData;
            end
        end
`endif
        // Hardwired zero and the not-ready blanking override everything.
        if (!ready || (ZERO_REG != 0 && a == '0))
            v = '0;
        return v;
    endfunction

    always_comb begin
        reg1  = rd(readAddr1);
        reg2  = rd(readAddr2);
        pair1 = {rd(rd_hi), rd(rd_lo)};
    end

endmodule
